window_5x5_gen: RTL and testbench
=================================

# window_5x5_gen

Streaming 5x5 window generator that sits directly upstream of the 5x5 Sobel edge filters (Edge_X and its Y counterpart). It accepts decoded 8-bit luma pixels in raster order, one per valid beat, and buffers four previous image lines. Each beat that completes a fully in-image 5x5 neighbourhood presents that neighbourhood as the 200-bit window bus the filters consume.

## Interface
Parameters:
- IMG_WIDTH, 64: pixels per line; must be ≥ 5.
- IMG_HEIGHT, 64: lines per frame; must be ≥ 5.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel beat qualifier; no backpressure, every valid beat is accepted.
- in_sof  in  1  start of frame; sampled only when in_valid=1.
- in_pixel  in  8  pixel value, unsigned.
- win_valid  out  1  one-cycle pulse: window holds a new complete neighbourhood.
- window  out  200  row r (0 = top/oldest line), column c (0 = leftmost/oldest): bits [40r+8c+7 : 40r+8c].
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- Counters col ∈ [0, IMG_WIDTH-1] and row ∈ [0, IMG_HEIGHT-1] give the position of the current beat.
- Beat with in_sof=1: treated as position (0,0) regardless of counter state; any partial frame is abandoned. Line buffer contents are not cleared.
- After each beat: col+1; at IMG_WIDTH-1, col→0 and row+1; at (IMG_HEIGHT-1, IMG_WIDTH-1), both →0 and frame_done pulses. The next beat starts a new frame even without in_sof.
- Four line buffers LB0..LB3, depth IMG_WIDTH, addressed by col. LBk holds line row-1-k.
- On each beat at column c: read LB0[c]..LB3[c] (old values), then write LB0[c]=in_pixel and LBk[c]=old LB(k-1)[c].
- Window register: 5x5 array of 8-bit values. On each beat, columns shift left (column c takes column c+1), and column 4 loads {row0=LB3[c], row1=LB2[c], row2=LB1[c], row3=LB0[c], row4=in_pixel}.
- A beat is window-complete when row ≥ 4 and col ≥ 4 (counter values of that beat). This yields (IMG_WIDTH-4)·(IMG_HEIGHT-4) windows per frame.
- At the start of each line, columns 0–3 of the window hold stale pixels from the previous line. They are never flagged valid.
- Cycles without in_valid change no state. window holds its value and win_valid is 0.

## Timing
- Reset values: win_valid=0, frame_done=0, window=0, col=0, row=0. Line buffer RAM is not reset; its contents are masked by the validity rule.
- Latency: window and win_valid update on the rising edge that accepts the completing beat. They are visible in the following cycle. frame_done follows the same timing, relative to the last beat.
- Throughput: one pixel per cycle sustained. Arbitrary bubbles are allowed and do not alter results.
- in_sof on the final beat of a frame: the sof takes precedence. That beat is position (0,0) and no frame_done is emitted.
- rst_n asserted mid-frame: the outputs and counters clear immediately. The first beat after release is (0,0).
- The line buffers use read-old-data-on-write at the same address. They may be implemented as register arrays or as distributed RAM with asynchronous read.

## Structure
- Shared filter package: PIX_W=8, KERNEL=5, WIN_W=200, and the window packing index function (40r+8c), so that this block and the Sobel filters agree on packing.
- One sub-module: line_buffer (parameter DEPTH; ports clk, we, addr, din, dout with old-data read). Instantiate it four times in a chain.
- Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).

## Test plan
Unless stated otherwise, use IMG_WIDTH=IMG_HEIGHT=8, in_sof on the first beat, and pixel = 16·row + col.
- Continuous frame → first win_valid follows beat (4,4), with window[7:0]=0x00, [39:32]=0x04, [199:160]=0x4443424140. Exactly 16 win_valid pulses occur, and frame_done pulses once after beat 64.
- Same frame, in_valid toggling every other cycle → identical sequence of 16 windows; window is stable between beats.
- in_sof reasserted at beat (row 2, col 3) → no win_valid until new-frame position (4,4). Then 16 windows follow, computed from post-sof data only.
- rst_n pulsed low at beat (5,2) → all outputs 0 during reset. The restarted frame produces 16 windows starting at beat (4,4).
- Frame with pixel = 10·col, with window fed into Edge_X → each valid window gives pixel_out = 96·10·... checked against a golden Sobel model. Every window's rows are identical column ramps.
- Back-to-back frames without a second in_sof → a second run of 16 windows, with frame_done after beat 128.

Source files
------------

// File: rtl/window_5x5_gen_pkg.sv
// Shared constants and window packing for the 5x5 window generator and the Sobel filters.
// Row r, column c of a window lives at bits [win_idx(r, c) +: PIX_W].
package window_5x5_gen_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned KERNEL = 5;
  localparam int unsigned WIN_W  = PIX_W * KERNEL * KERNEL;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * PIX_W * KERNEL + c * PIX_W;
  endfunction

endpackage

// File: rtl/window_5x5_gen_if.sv
// Pixel stream in, packed 5x5 window stream out.
interface window_5x5_gen_if import window_5x5_gen_pkg::*; ();

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             win_valid;
  logic [WIN_W-1:0] window;
  logic             frame_done;

  modport master (
    output in_valid,
    output in_sof,
    output in_pixel,
    input  win_valid,
    input  window,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_sof,
    input  in_pixel,
    output win_valid,
    output window,
    output frame_done
  );

endinterface

// File: rtl/window_5x5_gen_line_buffer.sv
// One line of pixel storage; asynchronous read returns the old word during a same-address write.
module line_buffer import window_5x5_gen_pkg::*; #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Contents are deliberately unreset; stale lines are masked by window validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/window_5x5_gen.sv
// Streaming 5x5 window generator: four chained line buffers feed the right column of a
// shifting 5x5 register window; complete in-image neighbourhoods are flagged with win_valid.
module window_5x5_gen import window_5x5_gen_pkg::*; #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input logic               clk,
  input logic               rst_n,
  window_5x5_gen_if.slave   bus
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned NUM_LB = KERNEL - 1;

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic             last_col, last_row;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [KERNEL-1:0][KERNEL-1:0][PIX_W-1:0] win_q, win_d;

  logic [PIX_W-1:0] lb_in  [NUM_LB];
  logic [PIX_W-1:0] lb_out [NUM_LB];

  // A sof beat is position (0,0) whatever the counters say.
  assign cur_col  = bus.in_sof ? '0 : col_q;
  assign cur_row  = bus.in_sof ? '0 : row_q;
  assign last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
  assign last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));

  for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = bus.in_pixel;
    end else begin : g_chain
      assign lb_in[k] = lb_out[k-1];
    end

    line_buffer #(
      .DEPTH (IMG_WIDTH)
    ) u_line_buffer (
      .clk  (clk),
      .we   (bus.in_valid),
      .addr (cur_col),
      .din  (lb_in[k]),
      .dout (lb_out[k])
    );
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (bus.in_valid) begin
      col_d = last_col ? '0 : cur_col + COL_W'(1);
      if (last_col) begin
        row_d = last_row ? '0 : cur_row + ROW_W'(1);
      end else begin
        row_d = cur_row;
      end
      frame_done_d = last_col && last_row;
      win_valid_d  = (cur_row >= ROW_W'(KERNEL - 1)) && (cur_col >= COL_W'(KERNEL - 1));

      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      // Oldest line (LB3) lands in the top row, the live pixel in the bottom row.
      for (int k = 0; k < NUM_LB; k++) begin
        win_d[k][KERNEL-1] = lb_out[NUM_LB-1-k];
      end
      win_d[KERNEL-1][KERNEL-1] = bus.in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    bus.window = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        bus.window[win_idx(r, c) +: PIX_W] = win_q[r][c];
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed bench for window_5x5_gen on an 8x8 image, checked against a pixel-array model.
module tb_window_5x5_gen;
  import window_5x5_gen_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_5x5_gen_if bus ();

  window_5x5_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int nwin, nfd, mrow, mcol;
  logic [7:0]       img [H][W];
  logic [WIN_W-1:0] exp_win, first_win;
  bit               first_seen;

  task automatic chk(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [7:0] p, input logic sof, input int gap);
    logic ev, efd;
    if (sof) begin
      mrow = 0;
      mcol = 0;
    end
    img[mrow][mcol] = p;
    ev  = (mrow >= 4) && (mcol >= 4);
    efd = (mrow == H - 1) && (mcol == W - 1);
    if (ev) begin
      for (int rr = 0; rr < 5; rr++)
        for (int cc = 0; cc < 5; cc++)
          exp_win[win_idx(rr, cc) +: 8] = img[mrow-4+rr][mcol-4+cc];
    end
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_pixel = p;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    chk("win_valid", WIN_W'(bus.win_valid), WIN_W'(ev));
    chk("frame_done", WIN_W'(bus.frame_done), WIN_W'(efd));
    if (ev) begin
      chk("window", bus.window, exp_win);
      if (!first_seen) begin
        first_win  = bus.window;
        first_seen = 1'b1;
      end
      nwin++;
    end
    if (efd) nfd++;
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
      chk("gap_valid", WIN_W'(bus.win_valid), '0);
      chk("gap_done", WIN_W'(bus.frame_done), '0);
      if (ev) chk("gap_hold", bus.window, exp_win);
    end
  endtask

  // mode 0: 16*row+col+base, mode 1: 10*col ramp
  task automatic frame(input int base, input logic sof, input int gap, input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        beat(mode == 1 ? 8'(10 * c) : 8'(16 * r + c + base), sof && r == 0 && c == 0, gap);
  endtask

  task automatic start_test();
    nwin = 0;
    nfd = 0;
    first_seen = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    mrow = 0;
    mcol = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win_valid", WIN_W'(bus.win_valid), '0);
    chk("rst_frame_done", WIN_W'(bus.frame_done), '0);
    chk("rst_window", bus.window, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame
    start_test();
    frame(0, 1'b1, 0, 0);
    chk("t1_nwin", WIN_W'(nwin), WIN_W'(16));
    chk("t1_nfd", WIN_W'(nfd), WIN_W'(1));
    chk("t1_first_lo", WIN_W'(first_win[7:0]), WIN_W'(8'h00));
    chk("t1_first_r0c4", WIN_W'(first_win[39:32]), WIN_W'(8'h04));
    chk("t1_first_row4", WIN_W'(first_win[199:160]), WIN_W'(40'h4443424140));

    // Bubbles every other cycle
    start_test();
    frame(0, 1'b1, 1, 0);
    chk("t2_nwin", WIN_W'(nwin), WIN_W'(16));
    chk("t2_nfd", WIN_W'(nfd), WIN_W'(1));

    // sof reasserted at (2,3)
    start_test();
    for (int i = 0; i < 2 * W + 3; i++) beat(8'(200 + i), i == 0, 0);
    frame(32, 1'b1, 0, 0);
    chk("t3_nwin", WIN_W'(nwin), WIN_W'(16));
    chk("t3_nfd", WIN_W'(nfd), WIN_W'(1));

    // Reset pulse just before beat (5,2)
    for (int i = 0; i < 5 * W + 2; i++) beat(8'(3 * i + 1), i == 0, 0);
    rst_n = 1'b0;
    #2;
    chk("t4_rst_valid", WIN_W'(bus.win_valid), '0);
    chk("t4_rst_done", WIN_W'(bus.frame_done), '0);
    chk("t4_rst_window", bus.window, '0);
    @(posedge clk);
    #1;
    chk("t4_rst_window_hold", bus.window, '0);
    rst_n = 1'b1;
    mrow = 0;
    mcol = 0;
    start_test();
    frame(5, 1'b0, 0, 0);
    chk("t4_nwin", WIN_W'(nwin), WIN_W'(16));
    chk("t4_nfd", WIN_W'(nfd), WIN_W'(1));

    // Column ramp: every window row is the same ramp
    start_test();
    frame(0, 1'b1, 0, 1);
    chk("t5_nwin", WIN_W'(nwin), WIN_W'(16));
    chk("t5_first", first_win, {5{40'h281E140A00}});

    // Back-to-back frames without sof
    start_test();
    frame(1, 1'b0, 0, 0);
    frame(2, 1'b0, 0, 0);
    chk("t6_nwin", WIN_W'(nwin), WIN_W'(32));
    chk("t6_nfd", WIN_W'(nfd), WIN_W'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
